// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and field positions for the TSP16 pipeline hazard controller.
// The PIPELINE_HAZARD_PERF_EN macro (top module) adds stall/flush counters.
package tsp16_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } pipe_state_t;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'd0;
  localparam fwd_sel_t FWD_EX  = 2'd1;
  localparam fwd_sel_t FWD_MEM = 2'd2;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  localparam logic [3:0] DEF_LOAD_OPCODE  = 4'hA;
  localparam logic [3:0] DEF_STORE_OPCODE = 4'hB;
  localparam int         DEF_FLUSH_CYCLES = 2;

endpackage

// File: rtl/pipeline_fwd_unit.sv
// Combinational operand-forwarding select for rs1/rs2; execute beats memory.
module pipeline_fwd_unit
  import tsp16_pipe_pkg::*;
(
  input  logic [2:0] rs1,
  input  logic [2:0] rs2,
  input  logic [2:0] ex_rd,
  input  logic       ex_fwd_ok,
  input  logic [2:0] mem_rd,
  input  logic       mem_fwd_ok,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // r0 is hardwired, so it never needs a forwarded value
  function automatic fwd_sel_t pick(input logic [2:0] src);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src != 3'd0) begin
      if (ex_fwd_ok && (ex_rd == src)) begin
        sel = FWD_EX;
      end else if (mem_fwd_ok && (mem_rd == src)) begin
        sel = FWD_MEM;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = pick(rs1);
    fwd_b = pick(rs2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// TSP16 pipeline hazard sequencer: stalls, bubbles, flushes, forwarding, dmem handshake.
// Define PIPELINE_HAZARD_PERF_EN to add saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import tsp16_pipe_pkg::*;
#(
  parameter int         FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter logic [3:0] LOAD_OPCODE  = DEF_LOAD_OPCODE,
  parameter logic [3:0] STORE_OPCODE = DEF_STORE_OPCODE
`ifdef PIPELINE_HAZARD_PERF_EN
  , parameter int       CNT_W        = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [15:0] dec_instr,
  input  logic        ex_done,
  input  logic        ex_is_dependent,
  input  logic [15:0] ex_instr,
  input  logic        mem_done,
  input  logic        mem_is_dependent,
  input  logic [15:0] mem_instr,
  input  logic        branch_taken,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        hold_fetch,
  output logic        hold_decode,
  output logic        bubble_execute,
  output logic        hold_memory,
  output logic        flush_decode,
`ifdef PIPELINE_HAZARD_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
`endif
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  pipe_state_t state, state_next;
  logic [2:0]  flush_cnt, cnt_next;

  logic [2:0] rs1, rs2, ex_rd, mem_rd;
  logic [3:0] ex_opc, mem_opc;
  logic       ex_is_load, mem_start, mem_stall, load_use;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       unused_bits;

  assign rs1     = dec_instr[RS1_HI:RS1_LO];
  assign rs2     = dec_instr[RS2_HI:RS2_LO];
  assign ex_rd   = ex_instr[RD_HI:RD_LO];
  assign ex_opc  = ex_instr[OPC_HI:OPC_LO];
  assign mem_rd  = mem_instr[RD_HI:RD_LO];
  assign mem_opc = mem_instr[OPC_HI:OPC_LO];
  assign unused_bits = ^{dec_instr[15:9], dec_instr[2:0], ex_instr[8:0], mem_instr[8:0]};

  assign ex_is_load = (ex_opc == LOAD_OPCODE);
  assign mem_start  = mem_done && ((mem_opc == LOAD_OPCODE) || (mem_opc == STORE_OPCODE));
  assign mem_stall  = mem_start && !dmem_ack;
  assign load_use   = ex_done && ex_is_dependent && ex_is_load && dec_valid &&
                      (((rs1 != 3'd0) && (rs1 == ex_rd)) || ((rs2 != 3'd0) && (rs2 == ex_rd)));

  pipeline_fwd_unit u_fwd (
    .rs1        (rs1),
    .rs2        (rs2),
    .ex_rd      (ex_rd),
    .ex_fwd_ok  (ex_done && ex_is_dependent && !ex_is_load),
    .mem_rd     (mem_rd),
    .mem_fwd_ok (mem_done && mem_is_dependent),
    .fwd_a      (fwd_a_raw),
    .fwd_b      (fwd_b_raw)
  );

  assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= cnt_next;
    end
  end

  // Outputs are gated by rst_n so an in-flight dmem_req drops the moment reset asserts
  always_comb begin
    state_next     = state;
    cnt_next       = flush_cnt;
    dmem_req       = 1'b0;
    hold_fetch     = 1'b0;
    hold_decode    = 1'b0;
    bubble_execute = 1'b0;
    hold_memory    = 1'b0;
    flush_decode   = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          dmem_req = mem_start;
          if (mem_stall) begin
            hold_fetch  = 1'b1;
            hold_decode = 1'b1;
            hold_memory = 1'b1;
            state_next  = MEM_WAIT;
          end else if (branch_taken) begin
            flush_decode   = 1'b1;
            bubble_execute = 1'b1;
            cnt_next       = FLUSH_LOAD;
            if (FLUSH_LOAD != 3'd0) state_next = FLUSH;
          end else if (load_use) begin
            hold_fetch     = 1'b1;
            hold_decode    = 1'b1;
            bubble_execute = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req    = 1'b1;
          hold_fetch  = 1'b1;
          hold_decode = 1'b1;
          hold_memory = 1'b1;
          if (dmem_ack) state_next = RUN;
        end
        FLUSH: begin
          dmem_req = mem_start;
          if (mem_stall) begin
            hold_fetch  = 1'b1;
            hold_decode = 1'b1;
            hold_memory = 1'b1;
            cnt_next    = 3'd0;
            state_next  = MEM_WAIT;
          end else begin
            flush_decode   = 1'b1;
            bubble_execute = 1'b1;
            cnt_next       = flush_cnt - 3'd1;
            if (flush_cnt <= 3'd1) begin
              cnt_next   = 3'd0;
              state_next = RUN;
            end
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

`ifdef PIPELINE_HAZARD_PERF_EN
  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hold_fetch && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush_decode && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default parameters).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, ex_done, ex_is_dependent, mem_done, mem_is_dependent;
  logic        branch_taken, dmem_ack;
  logic [15:0] dec_instr, ex_instr, mem_instr;
  logic        dmem_req, hold_fetch, hold_decode, bubble_execute, hold_memory, flush_decode;
  logic [1:0]  fwd_a, fwd_b;
`ifdef PIPELINE_HAZARD_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] ALU = 4'h1;
  localparam logic [3:0] LD  = 4'hA;
  localparam logic [3:0] ST  = 4'hB;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid        (dec_valid),
    .dec_instr        (dec_instr),
    .ex_done          (ex_done),
    .ex_is_dependent  (ex_is_dependent),
    .ex_instr         (ex_instr),
    .mem_done         (mem_done),
    .mem_is_dependent (mem_is_dependent),
    .mem_instr        (mem_instr),
    .branch_taken     (branch_taken),
    .dmem_ack         (dmem_ack),
    .dmem_req         (dmem_req),
    .hold_fetch       (hold_fetch),
    .hold_decode      (hold_decode),
    .bubble_execute   (bubble_execute),
    .hold_memory      (hold_memory),
    .flush_decode     (flush_decode),
`ifdef PIPELINE_HAZARD_PERF_EN
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_flush_cnt   (perf_flush_cnt),
`endif
    .fwd_a            (fwd_a),
    .fwd_b            (fwd_b)
  );

  function automatic logic [15:0] mk(input logic [3:0] opc, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {opc, rd, rs1, rs2, 3'b000};
  endfunction

  // {dmem_req, hold_fetch, hold_decode, bubble_execute, hold_memory, flush_decode, fwd_a, fwd_b}
  function automatic logic [9:0] outs();
    return {dmem_req, hold_fetch, hold_decode, bubble_execute, hold_memory, flush_decode, fwd_a, fwd_b};
  endfunction

  task automatic idle();
    dec_valid = 0; dec_instr = '0; ex_done = 0; ex_is_dependent = 0; ex_instr = '0;
    mem_done = 0; mem_is_dependent = 0; mem_instr = '0; branch_taken = 0; dmem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    mem_done = 1; mem_instr = mk(LD, 3'd1, 3'd0, 3'd0);
    ex_done = 1; ex_is_dependent = 1; ex_instr = mk(ALU, 3'd3, 3'd0, 3'd0);
    dec_valid = 1; dec_instr = mk(ALU, 3'd0, 3'd3, 3'd0);
    tick(); #2;
    checks++;
    if (outs() !== 10'b0_0_0_0_0_0_00_00) begin
      errors++; $display("[TB] FAIL reset_outs: got %b want %b", outs(), 10'b0);
    end
`ifdef PIPELINE_HAZARD_PERF_EN
    checks++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    idle();
    tick();
    rst_n = 1;
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL reset_release: got %b want %b", outs(), 10'b0);
    end
    tick();
  endtask

  task automatic test_alu_chain();
    idle();
    ex_done = 1; ex_is_dependent = 1; ex_instr = mk(ALU, 3'd3, 3'd0, 3'd0);
    dec_valid = 1; dec_instr = mk(ALU, 3'd0, 3'd3, 3'd5);
    #2;
    checks++;
    if (outs() !== 10'b0_0_0_0_0_0_01_00) begin
      errors++; $display("[TB] FAIL alu_ex_fwd: got %b want %b", outs(), 10'b0_0_0_0_0_0_01_00);
    end
    tick();
    ex_done = 0; ex_instr = '0;
    mem_done = 1; mem_is_dependent = 1; mem_instr = mk(ALU, 3'd3, 3'd0, 3'd0);
    #2;
    checks++;
    if (outs() !== 10'b0_0_0_0_0_0_10_00) begin
      errors++; $display("[TB] FAIL alu_mem_fwd: got %b want %b", outs(), 10'b0_0_0_0_0_0_10_00);
    end
    tick();
    ex_done = 1; ex_is_dependent = 1; ex_instr = mk(ALU, 3'd5, 3'd0, 3'd0);
    mem_instr = mk(ALU, 3'd5, 3'd0, 3'd0);
    #2;
    checks++;
    if (outs() !== 10'b0_0_0_0_0_0_00_01) begin
      errors++; $display("[TB] FAIL alu_ex_priority: got %b want %b", outs(), 10'b0_0_0_0_0_0_00_01);
    end
    tick();
    ex_is_dependent = 0; ex_instr = mk(ALU, 3'd3, 3'd0, 3'd0);
    mem_instr = mk(ALU, 3'd0, 3'd0, 3'd0);
    dec_instr = mk(ALU, 3'd0, 3'd3, 3'd0);
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL alu_no_match: got %b want %b", outs(), 10'b0);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ex_done = 1; ex_is_dependent = 1; ex_instr = mk(LD, 3'd2, 3'd0, 3'd0);
    dec_valid = 1; dec_instr = mk(ALU, 3'd0, 3'd4, 3'd2);
    #2;
    checks++;
    if (outs() !== 10'b0_1_1_1_0_0_00_00) begin
      errors++; $display("[TB] FAIL lu_stall: got %b want %b", outs(), 10'b0_1_1_1_0_0_00_00);
    end
    tick();
    ex_done = 0; ex_is_dependent = 0; ex_instr = '0;
    mem_done = 1; mem_is_dependent = 1; mem_instr = mk(LD, 3'd2, 3'd0, 3'd0);
    dmem_ack = 1;
    #2;
    checks++;
    if (outs() !== 10'b1_0_0_0_0_0_00_10) begin
      errors++; $display("[TB] FAIL lu_mem_fwd: got %b want %b", outs(), 10'b1_0_0_0_0_0_00_10);
    end
    tick();
    idle();
    ex_done = 1; ex_is_dependent = 1; ex_instr = mk(LD, 3'd2, 3'd0, 3'd0);
    dec_valid = 0; dec_instr = mk(ALU, 3'd0, 3'd4, 3'd2);
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL lu_dec_invalid: got %b want %b", outs(), 10'b0);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    idle();
    mem_done = 1; mem_is_dependent = 1; mem_instr = mk(LD, 3'd1, 3'd0, 3'd0);
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3);
      #2;
      checks++;
      if (outs() !== 10'b1_1_1_0_1_0_00_00) begin
        errors++; $display("[TB] FAIL mw_cycle%0d: got %b want %b", c, outs(), 10'b1_1_1_0_1_0_00_00);
      end
      tick();
    end
    idle();
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL mw_release: got %b want %b", outs(), 10'b0);
    end
    tick();
    mem_done = 1; mem_instr = mk(ST, 3'd0, 3'd0, 3'd0); dmem_ack = 1;
    #2;
    checks++;
    if (outs() !== 10'b1_0_0_0_0_0_00_00) begin
      errors++; $display("[TB] FAIL mw_zero_wait: got %b want %b", outs(), 10'b1_0_0_0_0_0_00_00);
    end
    tick();
    idle();
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL mw_zero_after: got %b want %b", outs(), 10'b0);
    end
    tick();
  endtask

  task automatic test_branch();
    idle();
    branch_taken = 1;
    #2;
    checks++;
    if (outs() !== 10'b0_0_0_1_0_1_00_00) begin
      errors++; $display("[TB] FAIL br_cycle0: got %b want %b", outs(), 10'b0_0_0_1_0_1_00_00);
    end
    tick();
    branch_taken = 0;
    #2;
    checks++;
    if (outs() !== 10'b0_0_0_1_0_1_00_00) begin
      errors++; $display("[TB] FAIL br_cycle1: got %b want %b", outs(), 10'b0_0_0_1_0_1_00_00);
    end
    tick();
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL br_done: got %b want %b", outs(), 10'b0);
    end
    tick();
  endtask

  task automatic test_branch_mem();
    idle();
    mem_done = 1; mem_is_dependent = 1; mem_instr = mk(LD, 3'd6, 3'd0, 3'd0);
    branch_taken = 1;
    #2;
    checks++;
    if (outs() !== 10'b1_1_1_0_1_0_00_00) begin
      errors++; $display("[TB] FAIL bm_defer: got %b want %b", outs(), 10'b1_1_1_0_1_0_00_00);
    end
    tick();
    dmem_ack = 1;
    #2;
    checks++;
    if (outs() !== 10'b1_1_1_0_1_0_00_00) begin
      errors++; $display("[TB] FAIL bm_wait_ignore: got %b want %b", outs(), 10'b1_1_1_0_1_0_00_00);
    end
    tick();
    mem_done = 0; mem_is_dependent = 0; mem_instr = '0; dmem_ack = 0;
    #2;
    checks++;
    if (outs() !== 10'b0_0_0_1_0_1_00_00) begin
      errors++; $display("[TB] FAIL bm_flush0: got %b want %b", outs(), 10'b0_0_0_1_0_1_00_00);
    end
    tick();
    branch_taken = 0;
    #2;
    checks++;
    if (outs() !== 10'b0_0_0_1_0_1_00_00) begin
      errors++; $display("[TB] FAIL bm_flush1: got %b want %b", outs(), 10'b0_0_0_1_0_1_00_00);
    end
    tick();
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL bm_run: got %b want %b", outs(), 10'b0);
    end
    tick();
  endtask

`ifdef PIPELINE_HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    rst_n = 0;
    #2;
    rst_n = 1;
    tick();
    mem_done = 1; mem_instr = mk(LD, 3'd1, 3'd0, 3'd0);
    tick();
    dmem_ack = 1;
    tick();
    idle();
    branch_taken = 1;
    tick();
    branch_taken = 0;
    tick();
    #2;
    checks++;
    if (perf_stall_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL perf_stall: got %0d want 2", perf_stall_cnt);
    end
    checks++;
    if (perf_flush_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL perf_flush: got %0d want 2", perf_flush_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_wait();
    idle();
    mem_done = 1; mem_instr = mk(LD, 3'd1, 3'd0, 3'd0);
    tick();
    #2;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL rmw_in_wait: got %b want 1", dmem_req);
    end
    rst_n = 0;
    #1;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL rmw_async_drop: got %b want %b", outs(), 10'b0);
    end
`ifdef PIPELINE_HAZARD_PERF_EN
    checks++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 32'd0) begin
      errors++; $display("[TB] FAIL rmw_perf_clear: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    idle();
    tick();
    rst_n = 1;
    #2;
    checks++;
    if (outs() !== 10'b0) begin
      errors++; $display("[TB] FAIL rmw_state_run: got %b want %b", outs(), 10'b0);
    end
    tick();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_branch_mem();
`ifdef PIPELINE_HAZARD_PERF_EN
    test_perf();
`endif
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
